// File: rtl/vid_pattern_gen.sv
// Source end of the vid_io pixel stream: 1080p60-style raster timing (hsync, vsync, VDE)
// with a selectable test pattern. Pixel packing is {R, B, G}, 8 bits per channel.
module vid_pattern_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_enable,
  input  logic [2:0]            i_pattern,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_vid_hsync,
  output logic                  o_vid_vsync,
  output logic                  o_vid_VDE,
  output logic [11:0]           o_hcount,
  output logic [10:0]           o_vcount,
  output logic                  o_frame_start
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [10:0] BAR_LIM  = 11'(H_ACTIVE);

  // Colour-bar edges: one eighth of the active width each, so h/240 becomes a range compare.
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [11:0] BAR_E1 = 12'(BAR_W * 1);
  localparam logic [11:0] BAR_E2 = 12'(BAR_W * 2);
  localparam logic [11:0] BAR_E3 = 12'(BAR_W * 3);
  localparam logic [11:0] BAR_E4 = 12'(BAR_W * 4);
  localparam logic [11:0] BAR_E5 = 12'(BAR_W * 5);
  localparam logic [11:0] BAR_E6 = 12'(BAR_W * 6);
  localparam logic [11:0] BAR_E7 = 12'(BAR_W * 7);

  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFF00FF;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h0000FF;
  localparam logic [23:0] C_MAGENTA = 24'hFFFF00;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h00FF00;

  logic [0:0]  state_q;
  logic [11:0] h_q;
  logic [10:0] v_q;
  logic [2:0]  pattern_q;
  logic [10:0] bar_x_q;

  logic            frame_first;
  logic            last_beat;
  logic            active;
  logic [2:0]      pattern_cur;
  logic [11:0]     bar_lo;
  logic [11:0]     bar_hi;
  logic [10:0]     bar_step;
  logic [10:0]     bar_next;
  logic [23:0]     pixel;

  assign frame_first = (h_q == 12'd0) && (v_q == 11'd0);
  assign last_beat   = (h_q == H_LAST) && (v_q == V_LAST);
  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  // The first beat of a frame already uses the newly selected pattern.
  assign pattern_cur = frame_first ? i_pattern : pattern_q;
  assign bar_lo      = {1'b0, bar_x_q};
  assign bar_hi      = bar_lo + 12'd64;
  assign bar_step    = bar_x_q + 11'd4;
  assign bar_next    = (bar_step >= BAR_LIM) ? 11'd0 : bar_step;

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves pixel unassigned (no latch).
    pixel = '0;
    if (active) begin
      case (pattern_cur)
        3'd0: begin
          if      (h_q < BAR_E1) pixel = C_WHITE;
          else if (h_q < BAR_E2) pixel = C_YELLOW;
          else if (h_q < BAR_E3) pixel = C_CYAN;
          else if (h_q < BAR_E4) pixel = C_GREEN;
          else if (h_q < BAR_E5) pixel = C_MAGENTA;
          else if (h_q < BAR_E6) pixel = C_RED;
          else if (h_q < BAR_E7) pixel = C_BLUE;
          else                   pixel = '0;
        end
        3'd1:    pixel = {3{h_q[10:3]}};
        3'd2:    pixel = (h_q[6] ^ v_q[6]) ? C_WHITE : '0;
        3'd3:    pixel = ((h_q >= bar_lo) && (h_q < bar_hi)) ? C_WHITE : '0;
        default: pixel = '0;
      endcase
    end
  end

  // NOTE: all state here is sequential, so every assignment below is non-blocking.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      pattern_q     <= '0;
      bar_x_q       <= '0;
      o_vid_data    <= '0;
      o_vid_hsync   <= 1'b0;
      o_vid_vsync   <= 1'b0;
      o_vid_VDE     <= 1'b0;
      o_hcount      <= '0;
      o_vcount      <= '0;
      o_frame_start <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          o_vid_data    <= DATA_WIDTH'(pixel);
          o_vid_hsync   <= (h_q >= HS_FIRST) && (h_q <= HS_LAST);
          o_vid_vsync   <= (v_q >= VS_FIRST) && (v_q <= VS_LAST);
          o_vid_VDE     <= active;
          o_hcount      <= h_q;
          o_vcount      <= v_q;
          o_frame_start <= frame_first;
          if (frame_first) pattern_q <= i_pattern;
          if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
          end else begin
            h_q <= h_q + 12'd1;
          end
          // Stopping is only considered on the final beat, so a frame is never cut short.
          // The bar position for the next frame is prepared here as well.
          if (last_beat) begin
            bar_x_q <= bar_next;
            if (!i_enable) state_q <= ST_IDLE;
          end
        end
        default: begin
          o_vid_data    <= '0;
          o_vid_hsync   <= 1'b0;
          o_vid_vsync   <= 1'b0;
          o_vid_VDE     <= 1'b0;
          o_hcount      <= '0;
          o_vcount      <= '0;
          o_frame_start <= 1'b0;
          h_q           <= '0;
          v_q           <= '0;
          if (i_enable) state_q <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen on a reduced raster (80x10 total, 72x6 active, 9-px bars)
// so that multi-frame behaviour, including the moving-bar wrap, fits a short run.
module tb_vid_pattern_gen;

  localparam int HT = 80;
  localparam int VT = 10;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        i_enable;
  logic [2:0]  i_pattern;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync;
  logic        o_vid_vsync;
  logic        o_vid_VDE;
  logic [11:0] o_hcount;
  logic [10:0] o_vcount;
  logic        o_frame_start;
  logic [50:0] all_out;

  int checks   = 0;
  int failures = 0;

  vid_pattern_gen #(
    .DATA_WIDTH(24), .H_ACTIVE(72), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_enable(i_enable), .i_pattern(i_pattern),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync),
    .o_vid_VDE(o_vid_VDE), .o_hcount(o_hcount), .o_vcount(o_vcount),
    .o_frame_start(o_frame_start)
  );

  always #5 clk = ~clk;

  assign all_out = {o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_hcount, o_vcount, o_frame_start};

  // Advance to the next output beat at (h, v); a beat at (0,0) must also carry frame_start.
  task automatic wait_beat(input int h, input int v);
    bit ok = 1'b0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      @(negedge clk);
      if (o_hcount == 12'(h) && o_vcount == 11'(v) && (h != 0 || v != 0 || o_frame_start)) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_beat h=%0d v=%0d: beat not seen within %0d cycles", h, v, 2 * HT * VT);
    end
  endtask

  task automatic wait_frame();
    bit ok = 1'b0;
    for (int n = 0; n < 2 * HT * VT; n++) begin
      @(negedge clk);
      if (o_frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL wait_frame: no frame_start within %0d cycles", 2 * HT * VT);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; i_enable = 1'b0; i_pattern = 3'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h, expected 0", all_out);
    end
    n_rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL idle_hold: got %h, expected 0", all_out);
    end
  endtask

  task automatic test_timing();
    int n = 0;
    i_enable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame_start !== 1'b1 && n < 10);
    checks++;
    if (n !== 2 || o_hcount !== 12'd0 || o_vcount !== 11'd0) begin
      failures++;
      $display("FAIL start_latency: got %0d cycles h=%0d v=%0d, expected 2 cycles h=0 v=0",
               n, o_hcount, o_vcount);
    end
    for (int f = 0; f < 3; f++) begin
      int cyc = 0, de = 0, hs = 0, vs = 0, fs = 0, bad = 0;
      int lh = 0, lv = 0;
      do begin
        cyc++;
        de += int'(o_vid_VDE);
        hs += int'(o_vid_hsync);
        vs += int'(o_vid_vsync);
        fs += int'(o_frame_start);
        if (o_vid_hsync !== (o_hcount >= 12'd74 && o_hcount <= 12'd76)) bad++;
        if (o_vid_vsync !== (o_vcount >= 11'd7 && o_vcount <= 11'd8)) bad++;
        if (o_vid_VDE !== (o_hcount < 12'd72 && o_vcount < 11'd6)) bad++;
        if (!o_vid_VDE && o_vid_data !== 24'h0) bad++;
        lh = int'(o_hcount);
        lv = int'(o_vcount);
        @(negedge clk);
      end while (o_frame_start !== 1'b1 && cyc < 2 * HT * VT);
      checks++;
      if (cyc !== 800) begin
        failures++; $display("FAIL frame_len f=%0d: got %0d, expected 800", f, cyc);
      end
      checks++;
      if (de !== 432 || hs !== 30 || vs !== 160 || fs !== 1) begin
        failures++;
        $display("FAIL frame_counts f=%0d: de=%0d hs=%0d vs=%0d fs=%0d, expected 432 30 160 1",
                 f, de, hs, vs, fs);
      end
      checks++;
      if (bad !== 0) begin
        failures++; $display("FAIL sync_positions f=%0d: %0d bad beats, expected 0", f, bad);
      end
      checks++;
      if (lh !== 79 || lv !== 9) begin
        failures++; $display("FAIL last_beat f=%0d: got h=%0d v=%0d, expected 79 9", f, lh, lv);
      end
    end
  endtask

  task automatic test_pattern0();
    int          th[10] = '{0, 8, 9, 18, 27, 36, 45, 54, 63, 71};
    logic [23:0] td[10] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                            24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000, 24'h000000};
    for (int i = 0; i < 10; i++) begin
      wait_beat(th[i], 1);
      checks++;
      if (o_vid_data !== td[i] || o_vid_VDE !== 1'b1) begin
        failures++;
        $display("FAIL bars h=%0d: data=%h de=%b, expected %h de=1", th[i], o_vid_data, o_vid_VDE, td[i]);
      end
    end
    wait_beat(72, 1);
    checks++;
    if (o_vid_data !== 24'h0 || o_vid_VDE !== 1'b0) begin
      failures++;
      $display("FAIL bars_blank h=72: data=%h de=%b, expected 000000 de=0", o_vid_data, o_vid_VDE);
    end
  endtask

  task automatic test_pattern_switch();
    int          rh[4] = '{0, 8, 16, 71};
    logic [23:0] rd[4] = '{24'h000000, 24'h010101, 24'h020202, 24'h080808};
    int          ch[3] = '{63, 64, 71};
    logic [23:0] cd[3] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF};
    wait_beat(0, 3);
    i_pattern = 3'd1;
    wait_beat(8, 4);
    checks++;
    if (o_vid_data !== 24'hFFFFFF) begin
      failures++; $display("FAIL ramp_too_early: got %h, expected FFFFFF", o_vid_data);
    end
    wait_frame();
    for (int i = 0; i < 4; i++) begin
      wait_beat(rh[i], 1);
      checks++;
      if (o_vid_data !== rd[i]) begin
        failures++; $display("FAIL ramp h=%0d: got %h, expected %h", rh[i], o_vid_data, rd[i]);
      end
    end
    wait_beat(0, 2);
    i_pattern = 3'd2;
    wait_beat(8, 3);
    checks++;
    if (o_vid_data !== 24'h010101) begin
      failures++; $display("FAIL checker_too_early: got %h, expected 010101", o_vid_data);
    end
    wait_frame();
    for (int i = 0; i < 3; i++) begin
      wait_beat(ch[i], 0);
      checks++;
      if (o_vid_data !== cd[i]) begin
        failures++; $display("FAIL checker h=%0d: got %h, expected %h", ch[i], o_vid_data, cd[i]);
      end
    end
  endtask

  task automatic test_moving_bar();
    n_rst = 1'b0; i_pattern = 3'd3; i_enable = 1'b1;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    for (int f = 0; f < 19; f++) begin
      int          b = (f * 4) % 72;
      int          ph[4];
      logic [23:0] pd[4];
      int          np = 0;
      if (b > 0) begin ph[np] = b - 1; pd[np] = 24'h0; np++; end
      ph[np] = b; pd[np] = 24'hFFFFFF; np++;
      ph[np] = (b + 63 < 72) ? b + 63 : 71; pd[np] = 24'hFFFFFF; np++;
      if (b + 64 < 72) begin ph[np] = b + 64; pd[np] = 24'h0; np++; end
      wait_frame();
      for (int i = 0; i < np; i++) begin
        if (ph[i] != 0) wait_beat(ph[i], 0);
        checks++;
        if (o_vid_data !== pd[i]) begin
          failures++;
          $display("FAIL bar f=%0d bar_x=%0d h=%0d: got %h, expected %h", f, b, ph[i], o_vid_data, pd[i]);
        end
      end
    end
  endtask

  task automatic test_stop();
    int nz = 0;
    int n  = 0;
    wait_beat(0, 3);
    i_enable = 1'b0;
    wait_beat(79, 9);
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL stop_idle: got %h, expected 0", all_out);
    end
    repeat (20) begin
      @(negedge clk);
      if (all_out !== '0) nz++;
    end
    checks++;
    if (nz !== 0) begin
      failures++; $display("FAIL stop_hold: %0d nonzero cycles, expected 0", nz);
    end
    i_enable = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame_start !== 1'b1 && n < 10);
    checks++;
    if (n !== 2) begin
      failures++; $display("FAIL restart_latency: got %0d, expected 2", n);
    end
    wait_beat(0, 3);
    i_enable = 1'b0;
    wait_beat(0, 7);
    i_enable = 1'b1;
    wait_beat(79, 9);
    @(negedge clk);
    checks++;
    if (o_frame_start !== 1'b1 || o_hcount !== 12'd0 || o_vcount !== 11'd0) begin
      failures++;
      $display("FAIL cancel_stop: fs=%b h=%0d v=%0d, expected fs=1 h=0 v=0", o_frame_start, o_hcount, o_vcount);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    wait_beat(10, 3);
    n_rst = 1'b0;
    @(negedge clk);
    checks++;
    if (all_out !== '0) begin
      failures++; $display("FAIL mid_reset: got %h, expected 0", all_out);
    end
    n_rst = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (o_frame_start !== 1'b1 && n < 10);
    checks++;
    if (n !== 2 || o_hcount !== 12'd0 || o_vcount !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset_restart: got %0d cycles h=%0d v=%0d, expected 2 cycles h=0 v=0",
               n, o_hcount, o_vcount);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_pattern0();
    test_pattern_switch();
    test_moving_bar();
    test_stop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
